// File: rtl/approx_mult_pkg.sv
// Shared helpers for the approximate multiplier: row truncation mask, OR-compressed
// row pair, and parameter legality check.
package approx_mult_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MAX_ZW    = 2 * MAX_WIDTH;

    // Ones in product columns [2*width-1:trunc], zeros elsewhere.
    function automatic logic [MAX_ZW-1:0] trunc_mask(input int unsigned width,
                                                     input int unsigned trunc);
        logic [MAX_ZW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_ZW; i++) begin
            m[i] = (i >= trunc) && (i < 2 * width);
        end
        return m;
    endfunction

    // Rows 2k and 2k+1 merged with OR instead of an adder.
    function automatic logic [MAX_ZW-1:0] pair_or(input logic [MAX_ZW-1:0] y,
                                                  input logic [1:0]        x2,
                                                  input int unsigned       k);
        logic [MAX_ZW-1:0] row_even;
        logic [MAX_ZW-1:0] row_odd;
        row_even = x2[0] ? (y << (2 * k))     : '0;
        row_odd  = x2[1] ? (y << (2 * k + 1)) : '0;
        return row_even | row_odd;
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned approx_rows,
                                        input int unsigned trunc,
                                        input int unsigned stages);
        return (width >= 1) && (width <= MAX_WIDTH) && (approx_rows % 2 == 0) &&
               (approx_rows <= width) && (trunc <= 2 * width) && (stages >= 1);
    endfunction

endpackage

// File: rtl/approx_mult_stage.sv
// One elastic register slice: holds valid + payload, loads when empty or drained.
module approx_mult_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready_c,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    input  logic         dn_ready
);

    assign up_ready_c = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned approximate multiplier with valid/ready handshake.
// Define ERR_MON_EN to add the exact shadow product and err_sum/err_max monitor.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_ROWS = 6,
    parameter int unsigned TRUNC       = 4,
    parameter int unsigned STAGES      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
`ifdef ERR_MON_EN
    ,
    input  logic               err_clr,
    output logic [31:0]        err_sum,
    output logic [2*WIDTH-1:0] err_max
`endif
);

    localparam int unsigned ZW = 2 * WIDTH;
    localparam int unsigned A  = APPROX_ROWS;
`ifdef ERR_MON_EN
    localparam int unsigned PLW = 3 * ZW;
`else
    localparam int unsigned PLW = 2 * ZW;
`endif

    if (!params_legal(WIDTH, APPROX_ROWS, TRUNC, STAGES)) begin : g_bad_params
        $error("approx_mult_pipe: illegal WIDTH/APPROX_ROWS/TRUNC/STAGES");
    end

    // Exact upper rows plus OR-compressed, truncated lower row pairs.
    logic [ZW-1:0] exact_c;
    logic [ZW-1:0] hi_c;
    logic [ZW-1:0] lo_c;

    always_comb begin
        exact_c = ZW'(x) * ZW'(y);
        hi_c    = exact_c;
        lo_c    = '0;
        if (!mode_exact && (A != 0)) begin
            hi_c = (ZW'(y) * ZW'(x >> A)) << A;
            for (int unsigned k = 0; k < A / 2; k++) begin
                lo_c = lo_c + ZW'(pair_or(MAX_ZW'(y), x[2*k +: 2], k) &
                                  trunc_mask(WIDTH, TRUNC));
            end
        end
    end

    // Payload fields: [ZW-1:0] hi (or z), [2ZW-1:ZW] lo sum, [3ZW-1:2ZW] exact.
    logic [PLW-1:0] p0;

    always_comb begin
        p0 = '0;
        if (STAGES == 1) begin
            p0[ZW-1:0] = hi_c + lo_c;
        end else begin
            p0[ZW-1:0]    = hi_c;
            p0[2*ZW-1:ZW] = lo_c;
        end
`ifdef ERR_MON_EN
        p0[PLW-1:2*ZW] = exact_c;
`endif
    end

    logic           vld [STAGES+1];
    logic           rdy [STAGES+1];
    logic [PLW-1:0] d   [1:STAGES];

    assign vld[0]      = in_valid;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [PLW-1:0] sin;
        if (i == 0) begin : g_first
            assign sin = p0;
        end else if (i == 1) begin : g_add
            // Final add sits between stage 1 and stage 2.
            assign sin[ZW-1:0]    = d[1][ZW-1:0] + d[1][2*ZW-1:ZW];
            assign sin[2*ZW-1:ZW] = '0;
`ifdef ERR_MON_EN
            assign sin[PLW-1:2*ZW] = d[1][PLW-1:2*ZW];
`endif
        end else begin : g_pass
            assign sin = d[i];
        end

        approx_mult_stage #(.W(PLW)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (vld[i]),
            .up_data    (sin),
            .up_ready_c (rdy[i]),
            .dn_valid   (vld[i+1]),
            .dn_data    (d[i+1]),
            .dn_ready   (rdy[i+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign z         = d[STAGES][ZW-1:0];

    logic unused_lo;
    assign unused_lo = ^d[STAGES][2*ZW-1:ZW];

`ifdef ERR_MON_EN
    localparam int unsigned SW = ((ZW > 32) ? ZW : 32) + 1;

    logic [ZW-1:0] err_c;
    logic [SW-1:0] sum_c;

    assign err_c = d[STAGES][PLW-1:2*ZW] - z;
    assign sum_c = SW'(err_sum) + SW'(err_c);

    // Error accumulation on each output transfer; clear wins over update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum <= '0;
            err_max <= '0;
        end else if (err_clr) begin
            err_sum <= '0;
            err_max <= '0;
        end else if (out_valid && out_ready) begin
            err_sum <= (|sum_c[SW-1:32]) ? 32'hFFFF_FFFF : sum_c[31:0];
            if (err_c > err_max) begin
                err_max <= err_c;
            end
        end
    end
`endif

endmodule
